pe_ctrl_seq: RTL and testbench

PE_CTRL_SEQ -- requirements
Module: pe_ctrl_seq

---
 rtl/pe_ctrl_pkg.sv | 17 +
 rtl/pe_ctrl_perf.sv | 24 ++
 rtl/pe_ctrl_seq.sv | 183 ++++++++++++++++++
 tb/tb_pe_ctrl_seq.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: shared types and constants for the PE control sequencer.
// Holds the sequencer state enum, dataflow encodings and field widths.
package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic DF_OS = 1'b0;
  localparam logic DF_WS = 1'b1;

  localparam int SHIFT_W = 5;
  localparam int LEN_W   = 5;

endpackage

// File: rtl/pe_ctrl_perf.sv
// pe_ctrl_perf: saturating busy/stall cycle counters for pe_ctrl_seq.
// Ports: clock, reset, busy, stall in; busy_cyc, stall_cyc [31:0] out.
module pe_ctrl_perf (
  input  logic        clock,
  input  logic        reset,
  input  logic        busy,
  input  logic        stall,
  output logic [31:0] busy_cyc,
  output logic [31:0] stall_cyc
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_cyc  <= '0;
      stall_cyc <= '0;
    end else begin
      if (busy && (busy_cyc != '1))
        busy_cyc <= busy_cyc + 32'd1;
      if (busy && stall && (stall_cyc != '1))
        stall_cyc <= stall_cyc + 32'd1;
    end
  end

endmodule

// File: rtl/pe_ctrl_seq.sv
// pe_ctrl_seq: turns accepted commands into per-beat PE array controls.
// In: clock, reset, cmd_* (valid/ready handshake), stall.
// Out: ctl_* beat fields, busy, err_bad_len.
// Define PE_CTRL_PERF_EN to add perf_busy_cyc/perf_stall_cyc.
module pe_ctrl_seq
  import pe_ctrl_pkg::*;
#(
  parameter int ROWS      = 16,
  parameter int ID_W      = 3,
  parameter int DRAIN_CYC = ROWS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dataflow,
  input  logic [SHIFT_W-1:0] cmd_shift,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               cmd_flush,
  input  logic               stall,
  output logic               ctl_valid,
  output logic               ctl_dataflow,
  output logic               ctl_propagate,
  output logic [SHIFT_W-1:0] ctl_shift,
  output logic [ID_W-1:0]    ctl_id,
  output logic               ctl_last,
  output logic               ctl_zero,
  output logic               busy,
  output logic               err_bad_len
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_busy_cyc,
  output logic [31:0]        perf_stall_cyc
`endif
);

  localparam int MAXC  = (ROWS > DRAIN_CYC) ? ROWS : DRAIN_CYC;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   lm1_q, lm1_d;
  logic               flush_q, flush_d;
  logic               df_q, df_d;
  logic [SHIFT_W-1:0] sh_q, sh_d;
  logic               prop_q, prop_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    nid_q, nid_d;
  logic               last_q, last_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;
  logic               fin;
  logic               legal;
  logic               take;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lm1_d     = lm1_q;
    flush_d   = flush_q;
    df_d      = df_q;
    sh_d      = sh_q;
    prop_d    = prop_q;
    id_d      = id_q;
    nid_d     = nid_q;
    last_d    = last_q;
    zero_d    = zero_q;
    err_d     = 1'b0;
    fin       = (state_q == RUN)
             && (cnt_q == CNT_W'(lm1_q));
    legal     = (cmd_len != '0)
             && (int'(cmd_len) <= ROWS);
    cmd_ready = (state_q == IDLE)
             || (fin && !stall && !flush_q);
    take      = cmd_valid && cmd_ready;

    unique case (state_q)
      IDLE: ;
      RUN: begin
        if (!stall) begin
          if (fin) begin
            last_d = 1'b0;
            if (flush_q) begin
              state_d = DRAIN;
              cnt_d   = '0;
              prop_d  = ~prop_q;
              zero_d  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d  = cnt_q + 1'b1;
            last_d = ((cnt_q + 1'b1) == CNT_W'(lm1_q));
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          if (cnt_q == DRAIN_LAST) begin
            state_d = IDLE;
            zero_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A take in RUN only happens on a final non-flush beat, so this
    // overrides the IDLE return and chains the next command bubble-free.
    if (take) begin
      if (legal) begin
        state_d = RUN;
        cnt_d   = '0;
        lm1_d   = cmd_len - 5'd1;
        flush_d = cmd_flush;
        df_d    = cmd_dataflow;
        sh_d    = cmd_shift;
        prop_d  = ~prop_q;
        id_d    = nid_q;
        nid_d   = nid_q + 1'b1;
        last_d  = (cmd_len == 5'd1);
        zero_d  = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lm1_q   <= '0;
      flush_q <= 1'b0;
      df_q    <= DF_OS;
      sh_q    <= '0;
      prop_q  <= 1'b0;
      id_q    <= '0;
      nid_q   <= '0;
      last_q  <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lm1_q   <= lm1_d;
      flush_q <= flush_d;
      df_q    <= df_d;
      sh_q    <= sh_d;
      prop_q  <= prop_d;
      id_q    <= id_d;
      nid_q   <= nid_d;
      last_q  <= last_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign ctl_valid     = busy && !stall;
  assign ctl_dataflow  = df_q;
  assign ctl_propagate = prop_q;
  assign ctl_shift     = sh_q;
  assign ctl_id        = id_q;
  assign ctl_last      = last_q;
  assign ctl_zero      = zero_q;
  assign err_bad_len   = err_q;

`ifdef PE_CTRL_PERF_EN
  pe_ctrl_perf u_perf (
    .clock     (clock),
    .reset     (reset),
    .busy      (busy),
    .stall     (stall),
    .busy_cyc  (perf_busy_cyc),
    .stall_cyc (perf_stall_cyc)
  );
`endif

endmodule

// File: tb/tb_pe_ctrl_seq.sv
// tb_pe_ctrl_seq: directed self-checking bench for pe_ctrl_seq.
// Each scenario task drives vectors and compares against hand values.
module tb_pe_ctrl_seq;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_dataflow = 1'b0;
  logic [4:0] cmd_shift = '0;
  logic [4:0] cmd_len = '0;
  logic       cmd_flush = 1'b0;
  logic       stall = 1'b0;
  logic       ctl_valid;
  logic       ctl_dataflow;
  logic       ctl_propagate;
  logic [4:0] ctl_shift;
  logic [2:0] ctl_id;
  logic       ctl_last;
  logic       ctl_zero;
  logic       busy;
  logic       err_bad_len;
`ifdef PE_CTRL_PERF_EN
  logic [31:0] perf_busy_cyc;
  logic [31:0] perf_stall_cyc;
`endif

  int npass = 0;
  int ntot  = 0;

  always #5 clock = ~clock;

  pe_ctrl_seq dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_dataflow  (cmd_dataflow),
    .cmd_shift     (cmd_shift),
    .cmd_len       (cmd_len),
    .cmd_flush     (cmd_flush),
    .stall         (stall),
    .ctl_valid     (ctl_valid),
    .ctl_dataflow  (ctl_dataflow),
    .ctl_propagate (ctl_propagate),
    .ctl_shift     (ctl_shift),
    .ctl_id        (ctl_id),
    .ctl_last      (ctl_last),
    .ctl_zero      (ctl_zero),
    .busy          (busy),
    .err_bad_len   (err_bad_len)
`ifdef PE_CTRL_PERF_EN
    ,
    .perf_busy_cyc (perf_busy_cyc),
    .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  function automatic logic [13:0] obs();
    return {ctl_valid, ctl_dataflow, ctl_propagate, ctl_id,
            ctl_shift, ctl_last, ctl_zero, busy};
  endfunction

  function automatic logic [13:0] ex(
    input logic v, input logic df, input logic p,
    input logic [2:0] id, input logic [4:0] sh,
    input logic l, input logic z, input logic b);
    return {v, df, p, id, sh, l, z, b};
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    stall = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    ntot++;
    if (obs() !== 14'h0) begin
      $display("FAIL rst_outs got %h exp %h", obs(), 14'h0);
    end else npass++;
    ntot++;
    if ({cmd_ready, err_bad_len} !== 2'b10) begin
      $display("FAIL rst_ready got %b exp 10", {cmd_ready, err_bad_len});
    end else npass++;
    tick();
    reset = 1'b0;
    #1;
    ntot++;
    if ({cmd_ready, obs()} !== {1'b1, 14'h0}) begin
      $display("FAIL rst_release got %h exp %h", {cmd_ready, obs()}, {1'b1, 14'h0});
    end else npass++;
  endtask

  task automatic test_os();
    do_reset();
    cmd_valid = 1'b1;
    cmd_dataflow = 1'b0;
    cmd_shift = 5'd3;
    cmd_len = 5'd4;
    cmd_flush = 1'b0;
    #1;
    ntot++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL os_ready got %b exp 1", cmd_ready);
    end else npass++;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      ntot++;
      if (obs() !== ex(1, 0, 1, 0, 3, i == 3, 0, 1)) begin
        $display("FAIL os_beat%0d got %h exp %h", i, obs(), ex(1, 0, 1, 0, 3, i == 3, 0, 1));
      end else npass++;
      tick();
    end
    #1;
    ntot++;
    if ({ctl_valid, busy, cmd_ready} !== 3'b001) begin
      $display("FAIL os_done got %b exp 001", {ctl_valid, busy, cmd_ready});
    end else npass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] pv;
    logic [3:0] lv;
    logic [2:0] idv;
    pv = 4'b0011;
    lv = 4'b1010;
    do_reset();
    cmd_valid = 1'b1;
    cmd_dataflow = 1'b0;
    cmd_shift = 5'd0;
    cmd_len = 5'd2;
    cmd_flush = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      cmd_valid = (i < 2);
      #1;
      idv = (i < 2) ? 3'd0 : 3'd1;
      ntot++;
      if (obs() !== ex(1, 0, pv[i], idv, 0, lv[i], 0, 1)) begin
        $display("FAIL b2b_beat%0d got %h exp %h", i, obs(), ex(1, 0, pv[i], idv, 0, lv[i], 0, 1));
      end else npass++;
      if (i < 2) begin
        ntot++;
        if (cmd_ready !== (i == 1)) begin
          $display("FAIL b2b_ready%0d got %b exp %b", i, cmd_ready, i == 1);
        end else npass++;
      end
      tick();
    end
    #1;
    ntot++;
    if ({ctl_valid, busy, cmd_ready} !== 3'b001) begin
      $display("FAIL b2b_done got %b exp 001", {ctl_valid, busy, cmd_ready});
    end else npass++;
  endtask

  task automatic test_bad_len();
    do_reset();
    cmd_valid = 1'b1;
    cmd_len = 5'd0;
    cmd_flush = 1'b0;
    #1;
    ntot++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL bad_ready got %b exp 1", cmd_ready);
    end else npass++;
    tick();
    cmd_len = 5'd17;
    #1;
    ntot++;
    if ({err_bad_len, ctl_valid, busy} !== 3'b100) begin
      $display("FAIL bad_len0 got %b exp 100", {err_bad_len, ctl_valid, busy});
    end else npass++;
    tick();
    cmd_valid = 1'b0;
    #1;
    ntot++;
    if ({err_bad_len, ctl_valid, busy} !== 3'b100) begin
      $display("FAIL bad_len17 got %b exp 100", {err_bad_len, ctl_valid, busy});
    end else npass++;
    tick();
    #1;
    ntot++;
    if ({err_bad_len, ctl_valid, busy} !== 3'b000) begin
      $display("FAIL bad_clear got %b exp 000", {err_bad_len, ctl_valid, busy});
    end else npass++;
    cmd_valid = 1'b1;
    cmd_len = 5'd1;
    cmd_shift = 5'd5;
    cmd_dataflow = 1'b1;
    tick();
    cmd_valid = 1'b0;
    #1;
    ntot++;
    if (obs() !== ex(1, 1, 1, 0, 5, 1, 0, 1)) begin
      $display("FAIL bad_next got %h exp %h", obs(), ex(1, 1, 1, 0, 5, 1, 0, 1));
    end else npass++;
    tick();
    #1;
    ntot++;
    if ({ctl_valid, busy, cmd_ready} !== 3'b001) begin
      $display("FAIL bad_done got %b exp 001", {ctl_valid, busy, cmd_ready});
    end else npass++;
  endtask

  task automatic test_drain();
    do_reset();
    cmd_valid = 1'b1;
    cmd_dataflow = 1'b1;
    cmd_shift = 5'd2;
    cmd_len = 5'd3;
    cmd_flush = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      ntot++;
      if (obs() !== ex(1, 1, 1, 0, 2, i == 2, 0, 1)) begin
        $display("FAIL drn_run%0d got %h exp %h", i, obs(), ex(1, 1, 1, 0, 2, i == 2, 0, 1));
      end else npass++;
      if (i == 2) begin
        ntot++;
        if (cmd_ready !== 1'b0) begin
          $display("FAIL drn_ready got %b exp 0", cmd_ready);
        end else npass++;
      end
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      #1;
      ntot++;
      if (obs() !== ex(1, 1, 0, 0, 2, 0, 1, 1)) begin
        $display("FAIL drn_beat%0d got %h exp %h", i, obs(), ex(1, 1, 0, 0, 2, 0, 1, 1));
      end else npass++;
      tick();
    end
    #1;
    ntot++;
    if ({ctl_valid, busy, cmd_ready, ctl_zero} !== 4'b0010) begin
      $display("FAIL drn_done got %b exp 0010", {ctl_valid, busy, cmd_ready, ctl_zero});
    end else npass++;
  endtask

  task automatic test_stall();
    logic [5:0] sv;
    logic [5:0] vv;
    logic [5:0] lv;
    int nb;
    sv = 6'b001100;
    vv = 6'b110011;
    lv = 6'b100000;
    nb = 0;
    do_reset();
    cmd_valid = 1'b1;
    cmd_dataflow = 1'b0;
    cmd_shift = 5'd1;
    cmd_len = 5'd4;
    cmd_flush = 1'b0;
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      stall = sv[c];
      #1;
      ntot++;
      if ({ctl_valid, ctl_last, busy} !== {vv[c], lv[c], 1'b1}) begin
        $display("FAIL stl_cyc%0d got %b exp %b", c, {ctl_valid, ctl_last, busy}, {vv[c], lv[c], 1'b1});
      end else npass++;
      if (ctl_valid) nb++;
      tick();
    end
    stall = 1'b0;
    #1;
    ntot++;
    if (nb !== 4) begin
      $display("FAIL stl_beats got %0d exp 4", nb);
    end else npass++;
    ntot++;
    if ({ctl_valid, busy, cmd_ready} !== 3'b001) begin
      $display("FAIL stl_done got %b exp 001", {ctl_valid, busy, cmd_ready});
    end else npass++;
`ifdef PE_CTRL_PERF_EN
    ntot++;
    if (perf_stall_cyc !== 32'd2) begin
      $display("FAIL perf_stall got %0d exp 2", perf_stall_cyc);
    end else npass++;
    ntot++;
    if (perf_busy_cyc !== 32'd6) begin
      $display("FAIL perf_busy got %0d exp 6", perf_busy_cyc);
    end else npass++;
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    cmd_valid = 1'b1;
    cmd_dataflow = 1'b0;
    cmd_shift = 5'd0;
    cmd_len = 5'd1;
    cmd_flush = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    cmd_valid = 1'b1;
    cmd_shift = 5'd4;
    cmd_len = 5'd8;
    tick();
    cmd_valid = 1'b0;
    #1;
    ntot++;
    if (obs() !== ex(1, 0, 0, 1, 4, 0, 0, 1)) begin
      $display("FAIL rmid_beat1 got %h exp %h", obs(), ex(1, 0, 0, 1, 4, 0, 0, 1));
    end else npass++;
    tick();
    reset = 1'b1;
    #1;
    ntot++;
    if ({cmd_ready, err_bad_len, obs()} !== {2'b10, 14'h0}) begin
      $display("FAIL rmid_abort got %h exp %h", {cmd_ready, err_bad_len, obs()}, {2'b10, 14'h0});
    end else npass++;
    tick();
    #1;
    ntot++;
    if (obs() !== 14'h0) begin
      $display("FAIL rmid_hold got %h exp %h", obs(), 14'h0);
    end else npass++;
    reset = 1'b0;
    tick();
    #1;
    ntot++;
    if ({cmd_ready, obs()} !== {1'b1, 14'h0}) begin
      $display("FAIL rmid_idle got %h exp %h", {cmd_ready, obs()}, {1'b1, 14'h0});
    end else npass++;
    cmd_valid = 1'b1;
    cmd_shift = 5'd0;
    cmd_len = 5'd2;
    tick();
    cmd_valid = 1'b0;
    #1;
    ntot++;
    if (obs() !== ex(1, 0, 1, 0, 0, 0, 0, 1)) begin
      $display("FAIL rmid_next got %h exp %h", obs(), ex(1, 0, 1, 0, 0, 0, 0, 1));
    end else npass++;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_os();
    test_back_to_back();
    test_bad_len();
    test_drain();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

endmodule
